dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Round-robin arbiter that shares the single user-side port of the AXI DRAM controller between `NUM_PORTS` requesters, such as the instruction fetch, the data cache and the DMA engine. It accepts one single-beat read or write per grant and drives exactly one `rd_en`/`wr_en` pulse into the controller. It then tracks that transaction until the controller returns to ready, and routes the read data or write acknowledgement back to the owning requester. It sits between the SoC bus masters and the DRAM controller, in the `ui_clk` domain.

## Interface
- `NUM_PORTS`, 2: number of requesters (2..4).
- `APP_ADDR_WIDTH`, 28: request address width.
- `APP_DATA_WIDTH`, 128: data width.
- `APP_MASK_WIDTH`, 16: byte mask width (1 = byte masked off).

Ports:
- `ui_clk` in 1: the only clock.
- `ui_rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_PORTS: per-port request valid.
- `req_ready` out NUM_PORTS: per-port accept. Combinational; one-hot or zero.
- `req_we` in NUM_PORTS: 1 = write, 0 = read.
- `req_addr` in NUM_PORTS*APP_ADDR_WIDTH: packed addresses, port 0 in the LSBs.
- `req_wdata` in NUM_PORTS*APP_DATA_WIDTH: packed write data.
- `req_mask` in NUM_PORTS*APP_MASK_WIDTH: packed masks.
- `rsp_valid` out NUM_PORTS: one-cycle completion pulse to the owning port.
- `rsp_rdata` out APP_DATA_WIDTH: read data, shared by all ports, qualified by `rsp_valid`.
- `dram_rd_en`, `dram_wr_en` out 1: command pulses to the controller.
- `dram_addr` out APP_ADDR_WIDTH, `dram_data` out APP_DATA_WIDTH, `dram_mask` out APP_MASK_WIDTH: command payload to the controller.
- `dram_ready` in 1: controller idle/ready. Registered by the controller; falls the cycle after a command is issued.
- `dram_rdata` in APP_DATA_WIDTH, `dram_rvalid` in 1: read return from the controller.
- `dram_calib_done` in 1: calibration complete.

## Operation
- State machine: ARB, ISSUE, WAIT_LOW, WAIT_RD, WAIT_WR.
- ARB:
  - If `dram_calib_done && dram_ready` and any `req_valid` is set, the round-robin winner `w` gets `req_ready[w]=1`.
  - On that grant, the block latches the winner's we, addr, wdata, mask and owner id, then moves to ISSUE.
  - Otherwise `req_ready=0`.
- ISSUE: for exactly one cycle, `dram_wr_en` or `dram_rd_en` is 1 with the latched payload; then → WAIT_LOW.
- WAIT_LOW: wait for `dram_ready==0`, which is guaranteed in this cycle. Then → WAIT_RD or WAIT_WR.
- WAIT_RD:
  - On `dram_rvalid`, capture `dram_rdata` into `rsp_rdata` and set the `data_seen` flag.
  - Issue the `rsp_valid[owner]` pulse on the next cycle.
  - When `dram_ready==1 && data_seen` → ARB, and clear `data_seen`.
  - If `dram_rvalid` and `dram_ready` arrive in the same cycle, the capture still occurs and the transition waits for the next cycle.
- WAIT_WR: on `dram_ready==1`, pulse `rsp_valid[owner]` on the next cycle and → ARB.
- Round robin:
  - The pointer holds the last granted port; search starts at pointer+1 and wraps modulo NUM_PORTS.
  - The pointer updates only on a grant.
  - After reset the pointer is NUM_PORTS-1, so port 0 has priority first.
- `dram_rvalid` seen outside WAIT_RD is ignored. `req_valid` on ports that are not granted is held by the requester; the arbiter never drops it.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `dram_rd_en=0`, `dram_wr_en=0`, `dram_addr/data/mask=0`, state ARB, pointer NUM_PORTS-1, `data_seen=0`.
- All outputs are registered except `req_ready`.
- Read latency: grant at T; `dram_rd_en` at T+1; if `dram_rvalid` arrives at R, `rsp_valid` is at R+1 and ARB is re-entered no earlier than R+2.
- Write latency: grant at T; `dram_wr_en` at T+1; if `dram_ready` returns at W, `rsp_valid` is at W+1 and the block is in ARB at W+1.
- Throughput: at most one outstanding transaction; no new grant until ARB and `dram_ready==1`.
- Calibration: while `dram_calib_done==0` no grant is given; requests stay pending.
- Reset mid-transaction: all state clears immediately and any pending response is lost. After reset, the block issues nothing until `dram_ready==1`, which lets the controller drain.

## Structure
- Package `dram_arb_pkg`: state enum and encodings, port-index width function `clog2`.
- Sub-module `rr_arbiter` (NUM_PORTS): request vector plus pointer in, one-hot grant plus index out; purely combinational. The pointer register lives in `dram_arbiter`.
- The top level holds the FSM, payload latch, owner id and response routing.

## Test plan
- Calibration gate: `dram_calib_done=0`, port 0 read pending for 20 cycles → no `dram_rd_en`. Raise calib → grant, then `dram_rd_en` exactly one cycle later.
- Single read: port 1 reads 0x100; model returns `dram_rvalid` 5 cycles after issue with data 0xDEAD → `rsp_valid[1]` one cycle later, `rsp_rdata=0xDEAD`, `rsp_valid[0]` stays 0.
- Single write: port 0 writes data 0x55, mask 0x0001 → `dram_wr_en` pulse with `dram_mask=0x0001`; `rsp_valid[0]` the cycle after `dram_ready` returns.
- Fairness: all ports request continuously → grants 0,1,0,1 (NUM_PORTS=2) or 0,1,2,3,0 (NUM_PORTS=4); no port is granted twice while another waits.
- Back-to-back: a read followed by a write on the same port → exactly one command in flight; the write is issued only after read `rsp_valid` and `dram_ready==1`.
- Async reset: assert `ui_rst_n=0` in WAIT_RD → all outputs 0 immediately; no `rsp_valid` after release; the next grant comes only once `dram_ready==1`.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types for the DRAM user-port arbiter: FSM state encoding and
// the port-index width helper.
package dram_arb_pkg;

  typedef enum logic [2:0] {
    ST_ARB      = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_LOW = 3'd2,
    ST_WAIT_RD  = 3'd3,
    ST_WAIT_WR  = 3'd4
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Requester-side bus of the DRAM arbiter: packed per-port requests and the
// shared response path. The arbiter is the slave, the SoC masters the master.
interface dram_arbiter_if #(
  parameter int NUM_PORTS      = 2,
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
);
  logic [NUM_PORTS-1:0]                req_valid;
  logic [NUM_PORTS-1:0]                req_ready;
  logic [NUM_PORTS-1:0]                req_we;
  logic [NUM_PORTS*APP_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*APP_DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS*APP_MASK_WIDTH-1:0] req_mask;
  logic [NUM_PORTS-1:0]                rsp_valid;
  logic [APP_DATA_WIDTH-1:0]           rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mask,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mask,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last
// granted port and wraps; the pointer register lives in the caller.
module rr_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [clog2(NUM_PORTS)-1:0] ptr,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [clog2(NUM_PORTS)-1:0] grant_idx
);
  localparam int IDX_W = clog2(NUM_PORTS);
  typedef logic [IDX_W-1:0] idx_t;

  idx_t cand;

  // Walk from lowest to highest priority so the last hit (closest to ptr+1) wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a latch.
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = idx_t'((int'(ptr) + k) % NUM_PORTS);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin sharing of the DRAM controller user port: one single-beat
// command per grant, tracked to completion and routed back to its owner.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
) (
  input  logic                      ui_clk,
  input  logic                      ui_rst_n,
  dram_arbiter_if.slave             bus,
  output logic                      dram_rd_en,
  output logic                      dram_wr_en,
  output logic [APP_ADDR_WIDTH-1:0] dram_addr,
  output logic [APP_DATA_WIDTH-1:0] dram_data,
  output logic [APP_MASK_WIDTH-1:0] dram_mask,
  input  logic                      dram_ready,
  input  logic [APP_DATA_WIDTH-1:0] dram_rdata,
  input  logic                      dram_rvalid,
  input  logic                      dram_calib_done
);
  localparam int IDX_W = clog2(NUM_PORTS);
  typedef logic [IDX_W-1:0] idx_t;

  arb_state_e                state;
  idx_t                      ptr;
  idx_t                      owner;
  idx_t                      grant_idx;
  logic [NUM_PORTS-1:0]      grant;
  logic [NUM_PORTS-1:0]      rsp_valid_q;
  logic [APP_DATA_WIDTH-1:0] rsp_rdata_q;
  logic                      cur_we;
  logic                      data_seen;
  logic                      arb_open;
  logic                      grant_fire;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grants only while idle, calibrated and the controller is ready; reset forces it shut.
  assign arb_open      = ui_rst_n && (state == ST_ARB) && dram_calib_done && dram_ready;
  assign grant_fire    = arb_open && (|bus.req_valid);
  assign bus.req_ready = arb_open ? grant : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values together.
  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      state       <= ST_ARB;
      ptr         <= idx_t'(NUM_PORTS - 1);
      owner       <= '0;
      cur_we      <= 1'b0;
      data_seen   <= 1'b0;
      dram_rd_en  <= 1'b0;
      dram_wr_en  <= 1'b0;
      dram_addr   <= '0;
      dram_data   <= '0;
      dram_mask   <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      dram_rd_en  <= 1'b0;
      dram_wr_en  <= 1'b0;
      rsp_valid_q <= '0;
      unique case (state)
        ST_ARB: begin
          if (grant_fire) begin
            ptr        <= grant_idx;
            owner      <= grant_idx;
            cur_we     <= bus.req_we[grant_idx];
            dram_addr  <= bus.req_addr[int'(grant_idx)*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
            dram_data  <= bus.req_wdata[int'(grant_idx)*APP_DATA_WIDTH +: APP_DATA_WIDTH];
            dram_mask  <= bus.req_mask[int'(grant_idx)*APP_MASK_WIDTH +: APP_MASK_WIDTH];
            dram_rd_en <= ~bus.req_we[grant_idx];
            dram_wr_en <= bus.req_we[grant_idx];
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT_LOW;
        ST_WAIT_LOW: begin
          if (!dram_ready) state <= cur_we ? ST_WAIT_WR : ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          if (dram_rvalid) begin
            rsp_rdata_q        <= dram_rdata;
            rsp_valid_q[owner] <= 1'b1;
            data_seen          <= 1'b1;
          end
          // data_seen is the registered flag, so a same-cycle rvalid+ready waits one cycle.
          if (dram_ready && data_seen) begin
            data_seen <= 1'b0;
            state     <= ST_ARB;
          end
        end
        ST_WAIT_WR: begin
          if (dram_ready) begin
            rsp_valid_q[owner] <= 1'b1;
            state              <= ST_ARB;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: vector table of single transactions plus
// hand-written sequences for calibration, fairness, back-to-back and reset.
module tb_dram_arbiter;
  localparam int NP = 2;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;

  logic          ui_clk;
  logic          ui_rst_n;
  logic          dram_rd_en, dram_wr_en;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_data;
  logic [MW-1:0] dram_mask;
  logic          dram_ready, dram_rvalid, dram_calib_done;
  logic [DW-1:0] dram_rdata;

  dram_arbiter_if #(.NUM_PORTS(NP), .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW),
                    .APP_MASK_WIDTH(MW)) bus ();

  dram_arbiter #(.NUM_PORTS(NP), .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW),
                 .APP_MASK_WIDTH(MW)) dut (
    .ui_clk          (ui_clk),
    .ui_rst_n        (ui_rst_n),
    .bus             (bus),
    .dram_rd_en      (dram_rd_en),
    .dram_wr_en      (dram_wr_en),
    .dram_addr       (dram_addr),
    .dram_data       (dram_data),
    .dram_mask       (dram_mask),
    .dram_ready      (dram_ready),
    .dram_rdata      (dram_rdata),
    .dram_rvalid     (dram_rvalid),
    .dram_calib_done (dram_calib_done)
  );

  initial begin
    ui_clk = 1'b0;
    forever #5 ui_clk = ~ui_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Controller model: ready drops the cycle after a command, rvalid after
  // m_rd_lat cycles, ready returns after m_ready_lat cycles (from issue).
  int            m_rd_lat, m_ready_lat, m_cnt;
  logic [DW-1:0] m_rdata;
  bit            m_pending, m_is_rd;

  initial begin
    dram_ready  = 1'b1;
    dram_rvalid = 1'b0;
    dram_rdata  = '0;
    m_pending   = 1'b0;
    m_is_rd     = 1'b0;
    m_cnt       = 0;
    forever begin
      @(posedge ui_clk);
      #1;
      dram_rvalid = 1'b0;
      if (m_pending) begin
        m_cnt++;
        if (m_cnt == 1) dram_ready = 1'b0;
        if (m_is_rd && m_cnt == m_rd_lat) begin
          dram_rvalid = 1'b1;
          dram_rdata  = m_rdata;
        end
        if (m_cnt == m_ready_lat) begin
          dram_ready = 1'b1;
          m_pending  = 1'b0;
        end
      end
      if (dram_rd_en || dram_wr_en) begin
        m_pending = 1'b1;
        m_cnt     = 0;
        m_is_rd   = dram_rd_en;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_pt();
    @(posedge ui_clk);
    #1;
  endtask

  function automatic logic [NP-1:0] onehot(input int p);
    return NP'(1) << p;
  endfunction

  task automatic set_req(input int p, input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    bus.req_valid[p]          = v;
    bus.req_we[p]             = we;
    bus.req_addr[p*AW +: AW]  = a;
    bus.req_wdata[p*DW +: DW] = d;
    bus.req_mask[p*MW +: MW]  = m;
  endtask

  typedef struct {
    int            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
    int            rd_lat;
    int            ready_lat;
    logic [DW-1:0] rdata;
    int            exp_lat;   // cycles from command issue to rsp_valid
    logic [NP-1:0] exp_rsp;
  } vec_t;

  vec_t vecs[6];

  task automatic run_txn(input vec_t v, input string tag);
    int waited, lat, extra;
    bit got;
    m_rd_lat    = v.rd_lat;
    m_ready_lat = v.ready_lat;
    m_rdata     = v.rdata;
    drive_pt();
    set_req(v.port, 1'b1, v.we, v.addr, v.wdata, v.mask);
    dram_calib_done = 1'b1;
    waited = 0;
    @(negedge ui_clk);
    while (bus.req_ready == '0 && waited < 100) begin
      drive_pt();
      @(negedge ui_clk);
      waited++;
    end
    check({tag, " grant_wait"}, waited, 0);
    check({tag, " req_ready"}, bus.req_ready, onehot(v.port));
    drive_pt();
    bus.req_valid[v.port] = 1'b0;
    @(negedge ui_clk);
    check({tag, " rd_en"}, dram_rd_en, !v.we);
    check({tag, " wr_en"}, dram_wr_en, v.we);
    check({tag, " addr"}, dram_addr, v.addr);
    check({tag, " mask"}, dram_mask, v.mask);
    if (v.we) check({tag, " wdata"}, dram_data, v.wdata);
    lat = 0; extra = 0; got = 1'b0;
    for (int k = 1; k <= 60 && !got; k++) begin
      drive_pt();
      @(negedge ui_clk);
      if (dram_rd_en || dram_wr_en) extra++;
      if (bus.rsp_valid != '0) begin
        got = 1'b1;
        lat = k;
      end
    end
    check({tag, " rsp_latency"}, lat, v.exp_lat);
    check({tag, " rsp_valid"}, bus.rsp_valid, v.exp_rsp);
    if (!v.we) check({tag, " rsp_rdata"}, bus.rsp_rdata, v.rdata);
    check({tag, " extra_cmds"}, extra, 0);
    for (int k = 0; k < 30 && !dram_ready; k++) begin
      drive_pt();
      @(negedge ui_clk);
    end
  endtask

  int            act, c_rd, c_wr, c_rsp1, c_rsp2, n_cmd, g_off, r_off, early_rsp, n_grant;
  bit            switched, granted;
  logic [NP-1:0] g_val, r_val;
  logic [DW-1:0] r_data;
  int            grants[6];
  int            exp_grants[6];

  initial begin
    vecs[0] = '{0, 1'b0, 28'h0000040, '0, 16'h0000, 4, 6, 128'hC0FFEE, 5, 2'b01};
    vecs[1] = '{1, 1'b0, 28'h0000100, '0, 16'h0000, 5, 7, 128'hDEAD, 6, 2'b10};
    vecs[2] = '{0, 1'b1, 28'h0000200, 128'h55, 16'h0001, 0, 4, '0, 5, 2'b01};
    vecs[3] = '{0, 1'b0, 28'hFFFFFFF, '0, 16'h0000, 3, 3, {128{1'b1}}, 4, 2'b01};
    vecs[4] = '{1, 1'b1, 28'h0000000, {4{32'hA5A5_5A5A}}, 16'hFFFF, 0, 2, '0, 3, 2'b10};
    vecs[5] = '{1, 1'b0, 28'h0ABCDEF, '0, 16'h00F0, 2, 9, 128'h1234, 3, 2'b10};
    exp_grants = '{0, 1, 0, 1, 0, 1};

    // Reset state, with requests pending and the controller ready.
    ui_rst_n        = 1'b0;
    dram_calib_done = 1'b1;
    bus.req_valid   = '1;
    bus.req_we      = '0;
    bus.req_addr    = '1;
    bus.req_wdata   = '1;
    bus.req_mask    = '1;
    m_rd_lat = 2; m_ready_lat = 3; m_rdata = '0;
    @(negedge ui_clk);
    @(negedge ui_clk);
    check("reset req_ready", bus.req_ready, '0);
    check("reset rsp_valid", bus.rsp_valid, '0);
    check("reset rsp_rdata", bus.rsp_rdata, '0);
    check("reset rd_en", dram_rd_en, 1'b0);
    check("reset wr_en", dram_wr_en, 1'b0);
    check("reset addr", dram_addr, '0);
    check("reset data", dram_data, '0);
    check("reset mask", dram_mask, '0);
    drive_pt();
    bus.req_valid   = '0;
    dram_calib_done = 1'b0;
    ui_rst_n        = 1'b1;

    // Calibration gate: a pending read must not be issued before calib.
    set_req(0, 1'b1, 1'b0, vecs[0].addr, '0, '0);
    act = 0;
    repeat (20) begin
      drive_pt();
      @(negedge ui_clk);
      if (bus.req_ready != '0 || dram_rd_en || dram_wr_en) act++;
    end
    check("calib_gate activity", act, 0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Fairness: both ports request continuously; last grant was port 1.
    m_rd_lat = 2; m_ready_lat = 3; m_rdata = 128'h77;
    drive_pt();
    set_req(0, 1'b1, 1'b0, 28'h10, '0, '0);
    set_req(1, 1'b1, 1'b0, 28'h20, '0, '0);
    n_grant = 0;
    for (int c = 0; c < 200 && n_grant < 6; c++) begin
      @(negedge ui_clk);
      if (bus.req_ready == 2'b01) begin grants[n_grant] = 0; n_grant++; end
      else if (bus.req_ready == 2'b10) begin grants[n_grant] = 1; n_grant++; end
      drive_pt();
    end
    bus.req_valid = '0;
    check("fair grant_count", n_grant, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("fair grant%0d", i), (i < n_grant) ? grants[i] : -1, exp_grants[i]);
    repeat (12) drive_pt();

    // Back-to-back on port 0: read, then a write presented right after the grant.
    m_rd_lat = 2; m_ready_lat = 5; m_rdata = 128'hB2B;
    c_rd = -1; c_wr = -1; c_rsp1 = -1; c_rsp2 = -1; n_cmd = 0; switched = 1'b0;
    drive_pt();
    set_req(0, 1'b1, 1'b0, 28'h300, '0, '0);
    for (int c = 0; c < 40; c++) begin
      @(negedge ui_clk);
      granted = bus.req_ready[0];
      if (dram_rd_en) begin n_cmd++; if (c_rd < 0) c_rd = c; end
      if (dram_wr_en) begin n_cmd++; if (c_wr < 0) c_wr = c; end
      if (bus.rsp_valid[0]) begin
        if (c_rsp1 < 0) c_rsp1 = c;
        else if (c_rsp2 < 0) c_rsp2 = c;
      end
      drive_pt();
      if (granted && !switched) begin
        set_req(0, 1'b1, 1'b1, 28'h304, 128'h99, 16'h0003);
        switched = 1'b1;
      end
      if (c_wr >= 0) bus.req_valid[0] = 1'b0;
    end
    check("b2b cmd_count", n_cmd, 2);
    check("b2b read_rsp_offset", c_rsp1 - c_rd, 3);
    check("b2b write_issue_offset", c_wr - c_rd, 7);
    check("b2b write_rsp_offset", c_rsp2 - c_wr, 6);

    // Async reset while waiting for read data on port 1.
    m_rd_lat = 6; m_ready_lat = 10; m_rdata = 128'hFACE;
    drive_pt();
    set_req(1, 1'b1, 1'b0, 28'h500, '0, 16'h00FF);
    @(negedge ui_clk);
    for (int k = 0; k < 50 && bus.req_ready == '0; k++) begin
      drive_pt();
      @(negedge ui_clk);
    end
    check("rst grant", bus.req_ready, 2'b10);
    drive_pt();                     // cycle C
    bus.req_valid[1] = 1'b0;
    @(negedge ui_clk);
    check("rst issue rd_en", dram_rd_en, 1'b1);
    repeat (3) drive_pt();          // cycle C+3, in WAIT_RD
    set_req(0, 1'b1, 1'b0, 28'h600, '0, '0);
    ui_rst_n = 1'b0;
    #1;
    check("rst async rd_en", dram_rd_en, 1'b0);
    check("rst async wr_en", dram_wr_en, 1'b0);
    check("rst async addr", dram_addr, '0);
    check("rst async mask", dram_mask, '0);
    check("rst async rsp_rdata", bus.rsp_rdata, '0);
    check("rst async rsp_valid", bus.rsp_valid, '0);
    check("rst async req_ready", bus.req_ready, '0);
    drive_pt();                     // C+4
    drive_pt();                     // C+5
    ui_rst_n = 1'b1;
    g_off = -1; r_off = -1; early_rsp = 0; g_val = '0; r_val = '0; r_data = '0;
    for (int off = 5; off <= 30; off++) begin
      @(negedge ui_clk);
      if (bus.req_ready != '0 && g_off < 0) begin
        g_off = off;
        g_val = bus.req_ready;
      end
      if (bus.rsp_valid != '0) begin
        if (g_off < 0) early_rsp++;
        else if (r_off < 0) begin
          r_off  = off;
          r_val  = bus.rsp_valid;
          r_data = bus.rsp_rdata;
        end
      end
      drive_pt();
      if (g_off >= 0) bus.req_valid[0] = 1'b0;
    end
    check("rst lost_rsp", early_rsp, 0);
    check("rst regrant_offset", g_off, 10);
    check("rst regrant_port", g_val, 2'b01);
    check("rst new_rsp_offset", r_off, 18);
    check("rst new_rsp_valid", r_val, 2'b01);
    check("rst new_rsp_rdata", r_data, 128'hFACE);

    repeat (5) drive_pt();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
